// File: rtl/cpu_clkgen.sv
// CPU clock generator: follows a synchronised CLK14M, divides CLK100M, runs at /2 or stops.
// Source changes pass through drain/park/start so CLKCPU never shows a runt high or short low.
`timescale 1ns/1ps
module cpu_clkgen #(
  parameter int SYNC_DEPTH  = 4,
  parameter int SYNC_TAP    = 1,
  parameter int INVERT_14M  = 1,
  parameter int DIV_WIDTH   = 4,
  parameter int PARK_CYCLES = 3
) (
  input  logic                 CLK100M,
  input  logic                 RESET,
  input  logic                 CLK14M,
  input  logic [1:0]           MODE,
  input  logic [DIV_WIDTH-1:0] DIV,
  output logic                 CLKCPU,
  output logic                 BUSY,
  output logic                 E14
);

  localparam int PW = (PARK_CYCLES > 1) ? $clog2(PARK_CYCLES) : 1;
  localparam logic [PW-1:0] PARK_INIT = PW'(PARK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_PARK  = 2'd2,
    ST_START = 2'd3
  } state_e;

  state_e                 state_q, state_d;
  logic [SYNC_DEPTH-1:0]  sr_q, sr_d;
  logic                   tap_prev_q;
  logic                   e14_q, e14_d;
  logic                   clk_q, clk_d;
  logic                   busy_q, busy_d;
  logic [1:0]             mode_q, mode_d;
  logic [DIV_WIDTH-1:0]   div_q, div_d;
  logic [DIV_WIDTH-1:0]   cnt_q, cnt_d;
  logic [PW-1:0]          park_q, park_d;

  logic                   in_s;
  logic                   tap_s;
  logic                   src_clk_s;
  logic [DIV_WIDTH-1:0]   src_cnt_s;
  logic                   req_s;
  logic                   unused_s;

  assign in_s     = (INVERT_14M != 0) ? ~CLK14M : CLK14M;
  assign sr_d     = {sr_q[SYNC_DEPTH-2:0], in_s};
  assign tap_s    = sr_q[SYNC_TAP];
  assign e14_d    = tap_s & ~tap_prev_q;
  assign unused_s = ^sr_q;

  // A switch is pending when the requested source differs from the one running.
  assign req_s = (MODE != mode_q) || ((mode_q == 2'b01) && (DIV != div_q));

  // Next value the currently active source would put on CLKCPU.
  always_comb begin
    src_clk_s = 1'b0;
    src_cnt_s = cnt_q;
    case (mode_q)
      2'b00: src_clk_s = tap_s;
      2'b01: begin
        if (cnt_q == div_q) begin
          src_clk_s = ~clk_q;
          src_cnt_s = '0;
        end else begin
          src_clk_s = clk_q;
          src_cnt_s = cnt_q + DIV_WIDTH'(1);
        end
      end
      2'b10: src_clk_s = ~clk_q;
      default: src_clk_s = 1'b0;
    endcase
  end

  // Switch sequencer: the old source finishes its high phase before the output parks low.
  always_comb begin
    state_d = state_q;
    clk_d   = clk_q;
    cnt_d   = cnt_q;
    park_d  = park_q;
    mode_d  = mode_q;
    div_d   = div_q;
    case (state_q)
      ST_RUN: begin
        clk_d = src_clk_s;
        cnt_d = src_cnt_s;
        if (req_s) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        clk_d = src_clk_s;
        cnt_d = src_cnt_s;
        if (!src_clk_s) begin
          state_d = ST_PARK;
          park_d  = PARK_INIT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_PARK: begin
        clk_d = 1'b0;
        if (park_q == '0) begin
          mode_d  = MODE;
          div_d   = DIV;
          state_d = ST_START;
        end else begin
          park_d = park_q - PW'(1);
        end
      end
      ST_START: begin
        clk_d = 1'b0;
        cnt_d = '0;
        // Follow mode only starts in the tap's low phase so the first high is full width.
        if ((mode_q != 2'b00) || !tap_s) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_START;
        end
      end
      default: begin
        clk_d   = 1'b0;
        state_d = ST_START;
      end
    endcase
  end

  assign busy_d = (state_d != ST_RUN);

  // State, synchroniser and registered outputs.
  always_ff @(posedge CLK100M or negedge RESET) begin
    if (!RESET) begin
      state_q    <= ST_START;
      sr_q       <= '0;
      tap_prev_q <= 1'b0;
      e14_q      <= 1'b0;
      clk_q      <= 1'b0;
      busy_q     <= 1'b1;
      mode_q     <= 2'b00;
      div_q      <= '0;
      cnt_q      <= '0;
      park_q     <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      tap_prev_q <= tap_s;
      e14_q      <= e14_d;
      clk_q      <= clk_d;
      busy_q     <= busy_d;
      mode_q     <= mode_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      park_q     <= park_d;
    end
  end

  assign CLKCPU = clk_q;
  assign BUSY   = busy_q;
  assign E14    = e14_q;

endmodule

// File: tb/tb_cpu_clkgen.sv
// Self-checking bench for cpu_clkgen: table of steady-state modes plus hand-written switch sequences.
`timescale 1ns/1ps
module tb_cpu_clkgen;

  logic       CLK100M, RESET, CLK14M;
  logic [1:0] MODE;
  logic [3:0] DIV;
  logic       CLKCPU, BUSY, E14;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  logic hist [0:8191];
  int   exp_q [$];

  typedef struct {
    logic [1:0] mode;
    logic [3:0] div;
    int         hi;
    int         lo;
  } vec_t;
  vec_t vecs [7];

  cpu_clkgen dut (
    .CLK100M(CLK100M), .RESET(RESET), .CLK14M(CLK14M),
    .MODE(MODE), .DIV(DIV),
    .CLKCPU(CLKCPU), .BUSY(BUSY), .E14(E14)
  );

  initial begin
    CLK100M = 1'b0;
    forever #5 CLK100M = ~CLK100M;
  end

  // 14.18 MHz-ish oscillator whose edges never coincide with a CLK100M edge.
  initial begin
    CLK14M = 1'b0;
    #0.1;
    forever #35.25 CLK14M = ~CLK14M;
  end

  always @(posedge CLK100M) begin
    hist[cyc & 8191] <= CLK14M;
    cyc <= cyc + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic h(input int k);
    return hist[k & 8191];
  endfunction

  task automatic tick();
    @(posedge CLK100M);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_pop(input string name, input int act);
    int e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s: got %0d expected <none queued>", name, act);
    end else begin
      e = exp_q.pop_front();
      chk(name, act, e);
    end
  endtask

  task automatic wait_idle(input string name);
    int t;
    tick();
    tick();
    t = 0;
    while (BUSY !== 1'b0 && t < 100) begin
      tick();
      t++;
    end
    chk({name, "_idle"}, int'(t < 100), 1);
  endtask

  task automatic wait_level(input logic v, input string name);
    int t;
    t = 0;
    while (CLKCPU !== v && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      checks++;
      failures++;
      $display("FAIL %s: CLKCPU never reached %0d", name, v);
    end
  endtask

  task automatic measure(output int hi, output int lo);
    int t;
    hi = -1;
    lo = -1;
    t = 0;
    while (CLKCPU !== 1'b0 && t < 200) begin tick(); t++; end
    while (CLKCPU !== 1'b1 && t < 200) begin tick(); t++; end
    if (t < 200) begin
      hi = 0;
      while (CLKCPU === 1'b1 && t < 400) begin hi++; tick(); t++; end
      lo = 0;
      while (CLKCPU === 1'b0 && t < 400) begin lo++; tick(); t++; end
      if (t >= 400) lo = -1;
    end
  endtask

  // CLKCPU must be the inverted CLK14M sample from two edges back; E14 marks its rising edges.
  task automatic follow_check(input string name, input int n);
    int   m, em, ep;
    logic exp_e;
    m = 0; em = 0; ep = 0;
    for (int i = 0; i < n; i++) begin
      if (CLKCPU !== ~h(cyc - 3)) m++;
      exp_e = ~h(cyc - 3) & h(cyc - 4);
      if (E14 !== exp_e) em++;
      if (E14 === 1'b1) ep++;
      tick();
    end
    chk({name, "_follow_errs"}, m, 0);
    chk({name, "_e14_errs"}, em, 0);
    chk({name, "_e14_pulses"}, ep, 20);
  endtask

  initial begin
    int hi, lo, t, ones, bc, busy_seen;
    vecs[0] = '{2'b10, 4'd0,  1,  1};
    vecs[1] = '{2'b01, 4'd3,  4,  4};
    vecs[2] = '{2'b01, 4'd0,  1,  1};
    vecs[3] = '{2'b01, 4'd7,  8,  8};
    vecs[4] = '{2'b01, 4'd15, 16, 16};
    vecs[5] = '{2'b10, 4'd5,  1,  1};
    vecs[6] = '{2'b10, 4'd9,  1,  1};

    MODE  = 2'b00;
    DIV   = 4'd0;
    RESET = 1'b1;
    #1 RESET = 1'b0;
    #1;
    chk("reset_clkcpu", int'(CLKCPU), 0);
    chk("reset_busy", int'(BUSY), 1);
    chk("reset_e14", int'(E14), 0);
    #30 RESET = 1'b1;

    t = 0;
    do begin tick(); t++; end while (BUSY !== 1'b0 && t < 10);
    chk("reset_busy_fall_cycles", t, 1);
    repeat (5) tick();
    follow_check("mode00", 141);

    for (int i = 0; i < 7; i++) begin
      MODE = vecs[i].mode;
      DIV  = vecs[i].div;
      exp_q.push_back(vecs[i].hi);
      exp_q.push_back(vecs[i].lo);
      wait_idle($sformatf("vec%0d", i));
      measure(hi, lo);
      chk_pop($sformatf("vec%0d_high", i), hi);
      chk_pop($sformatf("vec%0d_low", i), lo);
    end

    MODE = 2'b01;
    DIV  = 4'd3;
    wait_idle("div3");
    wait_level(1'b0, "div3_low");
    wait_level(1'b1, "div3_high");
    hi = 0; lo = 0; busy_seen = 0;
    while (CLKCPU === 1'b1 && hi < 50) begin
      hi++;
      if (hi == 2) DIV = 4'd0;
      tick();
      if (BUSY === 1'b1) busy_seen = 1;
    end
    while (CLKCPU === 1'b0 && lo < 50) begin
      lo++;
      tick();
      if (BUSY === 1'b1) busy_seen = 1;
    end
    exp_q.push_back(4);
    exp_q.push_back(5);
    chk_pop("divchg_high", hi);
    chk_pop("divchg_gap", lo);
    chk("divchg_busy_seen", busy_seen, 1);
    exp_q.push_back(1);
    exp_q.push_back(1);
    measure(hi, lo);
    chk_pop("divchg_new_high", hi);
    chk_pop("divchg_new_low", lo);

    MODE = 2'b10;
    wait_idle("to10");
    wait_level(1'b0, "to10_low");
    MODE = 2'b11;
    ones = 0; bc = 0;
    repeat (40) begin
      tick();
      if (CLKCPU === 1'b1) ones++;
      if (BUSY === 1'b1) bc++;
    end
    exp_q.push_back(1);
    exp_q.push_back(5);
    chk_pop("stop_high_cycles", ones);
    chk_pop("stop_busy_cycles", bc);

    MODE = 2'b00;
    wait_idle("restart00");
    follow_check("restart00", 141);

    wait_level(1'b0, "sw00_low");
    wait_level(1'b1, "sw00_high");
    hi = 0; lo = 0;
    while (CLKCPU === 1'b1 && hi < 50) begin
      hi++;
      if (hi == 1) MODE = 2'b10;
      tick();
    end
    while (CLKCPU === 1'b0 && lo < 50) begin
      lo++;
      tick();
    end
    chk("sw00_high_full", int'(hi >= 3 && hi <= 4), 1);
    exp_q.push_back(5);
    chk_pop("sw00_gap", lo);
    exp_q.push_back(1);
    exp_q.push_back(1);
    measure(hi, lo);
    chk_pop("sw00_new_high", hi);
    chk_pop("sw00_new_low", lo);

    wait_level(1'b0, "park_low");
    MODE = 2'b11;
    repeat (3) tick();
    #2 RESET = 1'b0;
    #1;
    chk("park_rst_clkcpu", int'(CLKCPU), 0);
    chk("park_rst_busy", int'(BUSY), 1);
    chk("park_rst_e14", int'(E14), 0);
    repeat (2) tick();
    #3 RESET = 1'b1;
    t = 0;
    do begin tick(); t++; end while (BUSY !== 1'b0 && t < 10);
    chk("park_rst_resume_cycles", t, 1);
    chk("park_rst_resume_clkcpu", int'(CLKCPU), 0);
    tick();
    chk("park_rst_reswitch_busy", int'(BUSY), 1);

    MODE = 2'b10;
    wait_idle("rsthigh");
    wait_level(1'b1, "rsthigh_high");
    #2 RESET = 1'b0;
    #1;
    chk("high_rst_clkcpu", int'(CLKCPU), 0);
    chk("high_rst_busy", int'(BUSY), 1);
    #5 RESET = 1'b1;
    repeat (3) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
